// File: rtl/fft_buf_pkg.sv
// Shared types, default widths and the bit-reversal helper for the FFT input buffer.
package fft_buf_pkg;

    localparam int unsigned DEF_ADDR_BITS = 9;
    localparam int unsigned DEF_DATA_BITS = 16;

    typedef enum logic [1:0] {
        FILL,
        DRAIN,
        WAIT_OUT
    } buf_state_t;

    // Reverses the low 'width' bits of addr; bits at or above 'width' come back as zero.
    function automatic logic [31:0] bitrev(input logic [31:0] addr, input int unsigned width);
        logic [31:0] r;
        r = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (i < width) begin
                r[5'(i)] = addr[5'(width - 1 - i)];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_buf_out_reg.sv
// One-entry output register with valid/ready; can_load_c says a new word may be loaded this cycle.
module fft_buf_out_reg
    import fft_buf_pkg::*;
#(
    parameter int unsigned DATA_BITS = DEF_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [DATA_BITS-1:0] load_data,
    input  logic                 out_ready,
    output logic                 can_load_c,
    output logic                 out_valid,
    output logic [DATA_BITS-1:0] out_data
);

    assign can_load_c = !out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= load_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fft_bitrev_sram_ctrl.sv
// FFT input buffer: writes a frame to SRAM in bit-reversed order, then streams it out in natural order.
// Macro FFT_BITREV_WRITE_EN selects bit-reversed write addressing; undefined writes in natural order.
module fft_bitrev_sram_ctrl
    import fft_buf_pkg::*;
#(
    parameter int unsigned ADDR_BITS = DEF_ADDR_BITS,
    parameter int unsigned DATA_BITS = DEF_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_BITS-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_BITS-1:0] out_data,
    output logic                 frame_done,
    output logic                 busy,
    output logic                 sram_read_enable,
    output logic                 sram_write_enable,
    output logic [ADDR_BITS-1:0] sram_address,
    output logic [DATA_BITS-1:0] sram_write_data,
    input  logic [DATA_BITS-1:0] sram_read_data
);

    localparam logic [ADDR_BITS-1:0] LAST_ADDR = '1;

    buf_state_t           state;
    buf_state_t           state_next;
    logic [ADDR_BITS-1:0] wr_cnt;
    logic [ADDR_BITS-1:0] rd_cnt;
    logic [ADDR_BITS-1:0] wr_addr;
    logic                 wr_fire;
    logic                 rd_fire;
    logic                 can_load;

`ifdef FFT_BITREV_WRITE_EN
    assign wr_addr = ADDR_BITS'(bitrev(32'(wr_cnt), ADDR_BITS));
`else
    assign wr_addr = wr_cnt;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    // Next state and same-cycle SRAM strobes; reads only when the output register can take the word
    always_comb begin
        state_next        = state;
        in_ready          = 1'b0;
        busy              = 1'b0;
        wr_fire           = 1'b0;
        rd_fire           = 1'b0;
        sram_write_enable = 1'b0;
        sram_read_enable  = 1'b0;
        sram_address      = '0;
        sram_write_data   = '0;
        case (state)
            FILL: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    wr_fire           = 1'b1;
                    sram_write_enable = 1'b1;
                    sram_address      = wr_addr;
                    sram_write_data   = in_data;
                    if (wr_cnt == LAST_ADDR) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (can_load) begin
                    rd_fire          = 1'b1;
                    sram_read_enable = 1'b1;
                    sram_address     = rd_cnt;
                    if (rd_cnt == LAST_ADDR) begin
                        state_next = WAIT_OUT;
                    end
                end
            end
            WAIT_OUT: begin
                busy = 1'b1;
                if (out_valid && out_ready) begin
                    state_next = FILL;
                end
            end
            default: state_next = FILL;
        endcase
    end

    // Frame counters wrap to zero naturally at N-1, which coincides with the frame boundary
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt     <= '0;
            rd_cnt     <= '0;
            frame_done <= 1'b0;
        end else begin
            if (wr_fire) begin
                wr_cnt <= wr_cnt + ADDR_BITS'(1);
            end
            if (rd_fire) begin
                rd_cnt <= rd_cnt + ADDR_BITS'(1);
            end
            frame_done <= (state == WAIT_OUT) && out_valid && out_ready;
        end
    end

    fft_buf_out_reg #(
        .DATA_BITS (DATA_BITS)
    ) u_out_reg (
        .clk        (clk),
        .rst        (rst),
        .load       (rd_fire),
        .load_data  (sram_read_data),
        .out_ready  (out_ready),
        .can_load_c (can_load),
        .out_valid  (out_valid),
        .out_data   (out_data)
    );

endmodule
